// File: rtl/fpu_sp_pkg.sv
// Shared binary32 definitions for the single-precision FPU datapath:
// field widths, constants, operand classes, divider FSM states and helpers.
package fpu_sp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 24;
  localparam int BIAS   = 127;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef enum logic [2:0] {
    FP_ZERO,
    FP_SUB,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_DIV,
    ST_ROUND,
    ST_DONE
  } div_state_e;

  // Classify the magnitude bits of a binary32 value; the sign does not matter.
  function automatic fp_class_e fp_classify(input logic [30:0] x);
    if (x[30:23] == 8'hFF) return (x[22:0] != 23'd0) ? FP_NAN : FP_INF;
    if (x[30:23] == 8'h00) return (x[22:0] != 23'd0) ? FP_SUB : FP_ZERO;
    return FP_NORM;
  endfunction

  // Leading-zero count of a 24-bit mantissa (24 when all zero).
  function automatic logic [4:0] lzc24(input logic [23:0] m);
    logic [4:0] n;
    n = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (m[i]) n = 5'(23 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/fp_div_seq_if.sv
// Request/response handshake bundle for the sequential binary32 divider.
interface fp_div_seq_if;
  import fpu_sp_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        div_by_zero;
  logic        invalid;

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, result, overflow, underflow, div_by_zero, invalid
  );

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, result, overflow, underflow, div_by_zero, invalid
  );

endinterface

// File: rtl/fp_sp_round.sv
// Combinational round-to-nearest-even and pack for binary32 results.
// Takes a normalized 24-bit mantissa (hidden bit included) with guard/sticky
// and a signed biased exponent. FP_DIV_SUBNORMAL_EN selects gradual underflow
// (denormalize then round); otherwise tiny results flush to signed zero.
module fp_sp_round
  import fpu_sp_pkg::*;
(
  input  logic              sign,
  input  logic signed [9:0] exp_in,
  input  logic [23:0]       mant,
  input  logic              guard,
  input  logic              sticky,
  output logic [31:0]       result,
  output logic              overflow,
  output logic              underflow
);

  logic              round_up;
  logic [24:0]       mant_inc;
  logic [22:0]       frac_rnd;
  logic signed [9:0] exp_adj;
`ifdef FP_DIV_SUBNORMAL_EN
  logic [9:0]        shamt;
  logic [49:0]       wide;
  logic [23:0]       d_mant;
  logic              d_guard;
  logic              d_sticky;
  logic [23:0]       d_rnd;
`endif

  // Round, renormalize on carry-out, then range-check and pack.
  always_comb begin
    result    = {sign, 31'd0};
    overflow  = 1'b0;
    underflow = 1'b0;
    round_up  = guard & (sticky | mant[0]);
    mant_inc  = {1'b0, mant} + 25'(round_up);
    frac_rnd  = mant_inc[24] ? mant_inc[23:1] : mant_inc[22:0];
    exp_adj   = mant_inc[24] ? exp_in + 10'sd1 : exp_in;
`ifdef FP_DIV_SUBNORMAL_EN
    shamt    = 10'd0;
    wide     = 50'd0;
    d_mant   = 24'd0;
    d_guard  = 1'b0;
    d_sticky = 1'b0;
    d_rnd    = 24'd0;
`endif
    if (exp_in <= 10'sd0) begin
`ifdef FP_DIV_SUBNORMAL_EN
      if (exp_in < -10'sd24) begin
        underflow = 1'b1;
      end else begin
        // Shift right by 1-e; everything below the new guard folds into sticky.
        shamt    = 10'sd1 - exp_in;
        wide     = {mant, guard, 25'd0} >> shamt;
        d_mant   = wide[49:26];
        d_guard  = wide[25];
        d_sticky = sticky | (|wide[24:0]);
        d_rnd    = d_mant + 24'(d_guard & (d_sticky | d_mant[0]));
        // A carry into bit 23 lands in the exponent LSB: smallest normal.
        result    = {sign, 31'(d_rnd)};
        underflow = d_guard | d_sticky;
      end
`else
      underflow = 1'b1;
`endif
    end else if (exp_adj >= 10'sd255) begin
      result   = {sign, POS_INF[30:0]};
      overflow = 1'b1;
    end else begin
      result = {sign, exp_adj[7:0], frac_rnd};
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// Iterative binary32 divider: result = dividend / divisor.
// Radix-2 restoring mantissa divide (26 quotient bits), RNE rounding and
// IEEE exception flags. One operation in flight; fixed latency of 28 cycles
// for ordinary operands and 1 cycle for special operands.
// Optional macro FP_DIV_SUBNORMAL_EN: normalize subnormal inputs and produce
// subnormal outputs; when undefined subnormals are treated as zero.
//
// state    | meaning
// ST_IDLE  | waiting for a request, in_ready high
// ST_PREP  | classify operands, resolve special cases, load divider
// ST_DIV   | one quotient bit per cycle, 26 cycles
// ST_ROUND | normalize, round and pack
// ST_DONE  | result held until out_ready
module fp_div_seq
  import fpu_sp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  fp_div_seq_if.slave bus
);

  div_state_e        state_q, state_d;
  logic [31:0]       a_q, b_q;
  logic [25:0]       rem_q, q_q;
  logic [23:0]       mb_q;
  logic signed [9:0] e_q;
  logic              sign_q;
  logic [4:0]        cnt_q;
  logic [31:0]       result_q;
  logic              ovf_q, unf_q, dbz_q, inv_q;

  fp_class_e         cls_a, cls_b;
  logic [23:0]       ma, mb;
  logic signed [9:0] ea, eb, e_prep;
  logic              is_special;
  logic [31:0]       sp_result;
  logic              sp_inv, sp_dbz;

  logic              ge;
  logic [25:0]       rem_sub, rem_next, q_next;

  logic signed [9:0] rn_e;
  logic [23:0]       rn_mant;
  logic              rn_guard, rn_sticky;
  logic [31:0]       rnd_result;
  logic              rnd_ovf, rnd_unf;

  // Operand unpack, classification and special-case resolution.
  always_comb begin
    cls_a = fp_classify(a_q[30:0]);
    cls_b = fp_classify(b_q[30:0]);
    ma    = {1'b1, a_q[22:0]};
    mb    = {1'b1, b_q[22:0]};
    ea    = $signed({2'b00, a_q[30:23]});
    eb    = $signed({2'b00, b_q[30:23]});
`ifdef FP_DIV_SUBNORMAL_EN
    if (cls_a == FP_SUB) begin
      ma = {1'b0, a_q[22:0]} << lzc24({1'b0, a_q[22:0]});
      ea = 10'sd1 - $signed({5'd0, lzc24({1'b0, a_q[22:0]})});
    end
    if (cls_b == FP_SUB) begin
      mb = {1'b0, b_q[22:0]} << lzc24({1'b0, b_q[22:0]});
      eb = 10'sd1 - $signed({5'd0, lzc24({1'b0, b_q[22:0]})});
    end
`else
    if (cls_a == FP_SUB) cls_a = FP_ZERO;
    if (cls_b == FP_SUB) cls_b = FP_ZERO;
`endif
    e_prep     = ea - eb + $signed(10'(BIAS));
    is_special = 1'b1;
    sp_result  = {a_q[31] ^ b_q[31], 31'd0};
    sp_inv     = 1'b0;
    sp_dbz     = 1'b0;
    if (cls_a == FP_NAN || cls_b == FP_NAN) begin
      sp_result = QNAN;
      sp_inv    = 1'b1;
    end else if ((cls_a == FP_ZERO && cls_b == FP_ZERO) ||
                 (cls_a == FP_INF && cls_b == FP_INF)) begin
      sp_result = QNAN;
      sp_inv    = 1'b1;
    end else if (cls_b == FP_ZERO) begin
      sp_result = {a_q[31] ^ b_q[31], POS_INF[30:0]};
      sp_dbz    = 1'b1;
    end else if (cls_a == FP_INF) begin
      sp_result = {a_q[31] ^ b_q[31], POS_INF[30:0]};
    end else if (cls_a == FP_ZERO || cls_b == FP_INF) begin
      sp_result = {a_q[31] ^ b_q[31], 31'd0};
    end else begin
      is_special = 1'b0;
    end
  end

  // One restoring-division step.
  always_comb begin
    ge       = rem_q >= {2'b00, mb_q};
    rem_sub  = ge ? rem_q - {2'b00, mb_q} : rem_q;
    rem_next = rem_sub << 1;
    q_next   = {q_q[24:0], ge};
  end

  // Normalize the quotient: a leading zero costs one exponent step.
  always_comb begin
    if (q_q[25]) begin
      rn_mant   = q_q[25:2];
      rn_guard  = q_q[1];
      rn_sticky = q_q[0] | (rem_q != 26'd0);
      rn_e      = e_q;
    end else begin
      rn_mant   = q_q[24:1];
      rn_guard  = q_q[0];
      rn_sticky = rem_q != 26'd0;
      rn_e      = e_q - 10'sd1;
    end
  end

  fp_sp_round u_round (
    .sign      (sign_q),
    .exp_in    (rn_e),
    .mant      (rn_mant),
    .guard     (rn_guard),
    .sticky    (rn_sticky),
    .result    (rnd_result),
    .overflow  (rnd_ovf),
    .underflow (rnd_unf)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.in_valid) state_d = ST_PREP;
      ST_PREP:  state_d = is_special ? ST_DONE : ST_DIV;
      ST_DIV:   if (cnt_q == 5'd25) state_d = ST_ROUND;
      ST_ROUND: state_d = ST_DONE;
      ST_DONE:  if (bus.out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Operand capture, divider datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      rem_q    <= 26'd0;
      q_q      <= 26'd0;
      mb_q     <= 24'd0;
      e_q      <= 10'sd0;
      sign_q   <= 1'b0;
      cnt_q    <= 5'd0;
      result_q <= 32'd0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dbz_q    <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_q <= bus.dividend;
            b_q <= bus.divisor;
          end
        end
        ST_PREP: begin
          sign_q <= a_q[31] ^ b_q[31];
          e_q    <= e_prep;
          rem_q  <= {2'b00, ma};
          mb_q   <= mb;
          q_q    <= 26'd0;
          cnt_q  <= 5'd0;
          if (is_special) begin
            result_q <= sp_result;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            dbz_q    <= sp_dbz;
            inv_q    <= sp_inv;
          end
        end
        ST_DIV: begin
          rem_q <= rem_next;
          q_q   <= q_next;
          cnt_q <= (cnt_q == 5'd25) ? 5'd0 : cnt_q + 5'd1;
        end
        ST_ROUND: begin
          result_q <= rnd_result;
          ovf_q    <= rnd_ovf;
          unf_q    <= rnd_unf;
          dbz_q    <= 1'b0;
          inv_q    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (state_q == ST_IDLE) && !rst;
  assign bus.out_valid   = state_q == ST_DONE;
  assign bus.result      = result_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.invalid     = inv_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq with hand-computed binary32 quotients.
module tb_fp_div_seq;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  fp_div_seq_if bus ();

  fp_div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {28'd0, bus.overflow, bus.underflow, bus.div_by_zero, bus.invalid};
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) check("idle_timeout", {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic [3:0] exp_flg,
                        input int exp_lat);
    int lat;
    wait_idle();
    bus.dividend  = a;
    bus.divisor   = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.out_valid && lat < 100);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, bus.result, exp_res);
    check({tag, "_flg"}, flags(), {28'd0, exp_flg});
    @(posedge clk); #1;
    check({tag, "_drop"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    int n;
    logic seen;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = 32'd0;
    bus.divisor   = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_flags", flags(), 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // flags order: {overflow, underflow, div_by_zero, invalid}
    run_op("six_by_two",  32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28);
    run_op("one_third",   32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 28);
    run_op("ten_third",   32'h41200000, 32'h40400000, 32'h40555555, 4'b0000, 28);
    run_op("one_fifth",   32'h3F800000, 32'h40A00000, 32'h3E4CCCCD, 4'b0000, 28);
    run_op("neg_six",     32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 28);
    run_op("one_by_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0010, 1);
    run_op("one_by_nzero",32'h3F800000, 32'h80000000, 32'hFF800000, 4'b0010, 1);
    run_op("zero_zero",   32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0001, 1);
    run_op("nan_in",      32'h7FA00000, 32'h3F800000, 32'h7FC00000, 4'b0001, 1);
    run_op("inf_inf",     32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b0001, 1);
    run_op("ninf_two",    32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1);
    run_op("nzero_five",  32'h80000000, 32'h40A00000, 32'h80000000, 4'b0000, 1);
    run_op("one_by_inf",  32'h3F800000, 32'h7F800000, 32'h00000000, 4'b0000, 1);
    run_op("overflow",    32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 4'b1000, 28);
`ifdef FP_DIV_SUBNORMAL_EN
    run_op("min_norm_half", 32'h00800000, 32'h40000000, 32'h00400000, 4'b0000, 28);
    run_op("sub_in",        32'h00000001, 32'h3F800000, 32'h00000001, 4'b0000, 28);
    run_op("sub_tie_even",  32'h00000003, 32'h40000000, 32'h00000002, 4'b0100, 28);
`else
    run_op("min_norm_half", 32'h00800000, 32'h40000000, 32'h00000000, 4'b0100, 28);
    run_op("sub_in",        32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 1);
    run_op("sub_tie_even",  32'h00000003, 32'h40000000, 32'h00000000, 4'b0000, 1);
`endif

    // Backpressure with a stray request during DIV.
    wait_idle();
    bus.dividend  = 32'h40C00000;
    bus.divisor   = 32'h40000000;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus.dividend = 32'h3F800000;
    bus.divisor  = 32'h00000000;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 11;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_lat", 32'(n), 32'd28);
    check("bp_res", bus.result, 32'h40400000);
    check("bp_flg", flags(), 32'd0);
    repeat (10) begin
      @(posedge clk); #1;
      check("bp_hold_res", bus.result, 32'h40400000);
      check("bp_hold_hs", {30'd0, bus.out_valid, bus.in_ready}, 32'd2);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
    check("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);

    // Reset during DIV iteration 12 aborts the operation.
    bus.dividend = 32'h40C00000;
    bus.divisor  = 32'h40000000;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_valid", {31'd0, bus.out_valid}, 32'd0);
    check("abort_ready_in_rst", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("abort_ready_after", {31'd0, bus.in_ready}, 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen = seen | bus.out_valid;
    end
    check("abort_no_result", {31'd0, seen}, 32'd0);
    run_op("after_abort", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
